// File: rtl/icache_fetch_ctrl.sv
// Fetch sequencing between the core fetch port and the instruction cache arrays:
// line lookup, halfword extraction, miss refill and cross-line 32-bit splicing.
module icache_fetch_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int BLOCK_SIZE = 128
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  fetch_req_i,
    input  logic [ADDR_W-1:0]     fetch_pc_i,
    output logic                  fetch_ready_o,
    output logic                  instr_valid_o,
    output logic [31:0]           instr_o,
    output logic                  instr_compressed_o,
    output logic [ADDR_W-5:0]     lookup_line_o,
    input  logic                  lookup_hit_i,
    input  logic [BLOCK_SIZE-1:0] lookup_data_i,
    output logic                  mem_req_o,
    output logic [ADDR_W-5:0]     mem_line_o,
    input  logic                  mem_ack_i,
    input  logic [BLOCK_SIZE-1:0] mem_data_i,
    output logic                  fill_we_o,
    output logic [ADDR_W-5:0]     fill_line_o,
    output logic [BLOCK_SIZE-1:0] fill_data_o
);
    localparam int LINE_W = ADDR_W - 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOOK0 = 3'd1,
        MISS0 = 3'd2,
        FILL0 = 3'd3,
        LOOK1 = 3'd4,
        MISS1 = 3'd5,
        FILL1 = 3'd6,
        RESP  = 3'd7
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_W-1:1]     pc_q;
    logic [15:0]           low_q;
    logic [31:0]           instr_q, instr_nxt;
    logic                  comp_q, comp_nxt;
    logic [BLOCK_SIZE-1:0] fill_data_q;
    logic                  load_pc, load_low, load_instr, load_fill;
    logic [LINE_W-1:0]     line0, line1;
    logic [2:0]            hw_idx;
    logic [15:0]           hw_lo, hw_hi;
    logic                  on_line1;
    logic                  unused_pc0;

    function automatic logic [15:0] extract_hw(input logic [BLOCK_SIZE-1:0] blk,
                                               input logic [2:0] idx);
        return blk[{idx, 4'b0000} +: 16];
    endfunction

    function automatic logic is_compressed(input logic [15:0] hw);
        return hw[1:0] != 2'b11;
    endfunction

    // Byte-address bit 0 never selects anything in a halfword-aligned fetch.
    assign unused_pc0 = fetch_pc_i[0];

    assign line0    = pc_q[ADDR_W-1:4];
    assign line1    = line0 + LINE_W'(1);
    assign hw_idx   = pc_q[3:1];
    assign hw_lo    = extract_hw(lookup_data_i, hw_idx);
    assign hw_hi    = extract_hw(lookup_data_i, hw_idx + 3'd1);
    assign on_line1 = (state == LOOK1) || (state == MISS1) || (state == FILL1);

    always_comb begin
        state_nxt  = state;
        load_pc    = 1'b0;
        load_low   = 1'b0;
        load_instr = 1'b0;
        load_fill  = 1'b0;
        instr_nxt  = instr_q;
        comp_nxt   = comp_q;
        case (state)
            IDLE: begin
                if (fetch_req_i) begin
                    load_pc   = 1'b1;
                    state_nxt = LOOK0;
                end
            end
            LOOK0: begin
                if (!lookup_hit_i) begin
                    state_nxt = MISS0;
                end else if (is_compressed(hw_lo)) begin
                    instr_nxt  = {16'b0, hw_lo};
                    comp_nxt   = 1'b1;
                    load_instr = 1'b1;
                    state_nxt  = RESP;
                end else if (hw_idx != 3'd7) begin
                    instr_nxt  = {hw_hi, hw_lo};
                    comp_nxt   = 1'b0;
                    load_instr = 1'b1;
                    state_nxt  = RESP;
                end else begin
                    // Upper half lives in the next line; keep the lower half.
                    load_low  = 1'b1;
                    state_nxt = LOOK1;
                end
            end
            MISS0: begin
                if (mem_ack_i) begin
                    load_fill = 1'b1;
                    state_nxt = FILL0;
                end
            end
            FILL0: state_nxt = LOOK0;
            LOOK1: begin
                if (lookup_hit_i) begin
                    instr_nxt  = {lookup_data_i[15:0], low_q};
                    comp_nxt   = 1'b0;
                    load_instr = 1'b1;
                    state_nxt  = RESP;
                end else begin
                    state_nxt = MISS1;
                end
            end
            MISS1: begin
                if (mem_ack_i) begin
                    load_fill = 1'b1;
                    state_nxt = FILL1;
                end
            end
            FILL1: state_nxt = LOOK1;
            RESP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            instr_q     <= '0;
            comp_q      <= 1'b0;
            fill_data_q <= '0;
        end else begin
            state <= state_nxt;
            if (load_instr) begin
                instr_q <= instr_nxt;
                comp_q  <= comp_nxt;
            end
            if (load_fill) begin
                fill_data_q <= mem_data_i;
            end
        end
    end

    // Address and spliced-half registers are only read after being loaded.
    always_ff @(posedge clk_i) begin
        if (load_pc) begin
            pc_q <= fetch_pc_i[ADDR_W-1:1];
        end
        if (load_low) begin
            low_q <= hw_lo;
        end
    end

    assign fetch_ready_o      = (state == IDLE);
    assign instr_valid_o      = (state == RESP);
    assign instr_o            = instr_q;
    assign instr_compressed_o = comp_q;
    assign lookup_line_o      = on_line1 ? line1 : line0;

    assign mem_req_o   = (state == MISS0) || (state == MISS1);
    assign mem_line_o  = (state == MISS0) ? line0 :
                         (state == MISS1) ? line1 : '0;
    assign fill_we_o   = (state == FILL0) || (state == FILL1);
    assign fill_line_o = (state == FILL0) ? line0 :
                         (state == FILL1) ? line1 : '0;
    assign fill_data_o = fill_data_q;

endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// Scoreboard bench for icache_fetch_ctrl: a small cache/memory model answers
// lookups and refills; a monitor checks every instr_valid_o against a queue.
module tb_icache_fetch_ctrl;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         fetch_req_i;
    logic [31:0]  fetch_pc_i;
    logic         fetch_ready_o;
    logic         instr_valid_o;
    logic [31:0]  instr_o;
    logic         instr_compressed_o;
    logic [27:0]  lookup_line_o;
    logic         lookup_hit_i;
    logic [127:0] lookup_data_i;
    logic         mem_req_o;
    logic [27:0]  mem_line_o;
    logic         mem_ack_i;
    logic [127:0] mem_data_i;
    logic         fill_we_o;
    logic [27:0]  fill_line_o;
    logic [127:0] fill_data_o;

    icache_fetch_ctrl dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .fetch_req_i        (fetch_req_i),
        .fetch_pc_i         (fetch_pc_i),
        .fetch_ready_o      (fetch_ready_o),
        .instr_valid_o      (instr_valid_o),
        .instr_o            (instr_o),
        .instr_compressed_o (instr_compressed_o),
        .lookup_line_o      (lookup_line_o),
        .lookup_hit_i       (lookup_hit_i),
        .lookup_data_i      (lookup_data_i),
        .mem_req_o          (mem_req_o),
        .mem_line_o         (mem_line_o),
        .mem_ack_i          (mem_ack_i),
        .mem_data_i         (mem_data_i),
        .fill_we_o          (fill_we_o),
        .fill_line_o        (fill_line_o),
        .fill_data_o        (fill_data_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        comp;
        int          cyc;
        int          id;
    } exp_t;

    exp_t         exp_q[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           cyc     = 0;

    bit           c_vld [8];
    logic [27:0]  c_tag [8];
    logic [127:0] c_dat [8];
    logic [27:0]  be_tag [4];
    logic [127:0] be_dat [4];
    int           be_n = 0;

    int           ack_dly    = 0;
    bit           inject_ack = 1'b0;
    int           fills      = 0;
    int           req_cycles = 0;
    logic [27:0]  last_fill_line = '0;
    logic [27:0]  last_mem_line  = '0;

    localparam logic [127:0] FILLER = {8{16'h0001}};

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        lookup_hit_i  = 1'b0;
        lookup_data_i = '0;
        for (int s = 0; s < 8; s++) begin
            if (c_vld[s] && c_tag[s] == lookup_line_o) begin
                lookup_hit_i  = 1'b1;
                lookup_data_i = c_dat[s];
            end
        end
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, required %08h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] blk_with(input logic [127:0] base, input int idx,
                                             input logic [15:0] v);
        logic [127:0] b;
        b = base;
        b[idx*16 +: 16] = v;
        return b;
    endfunction

    function automatic logic [127:0] backing(input logic [27:0] line);
        logic [127:0] d;
        d = FILLER;
        for (int k = 0; k < be_n; k++)
            if (be_tag[k] == line) d = be_dat[k];
        return d;
    endfunction

    task automatic cache_write(input logic [27:0] line, input logic [127:0] dat);
        int slot;
        slot = -1;
        for (int s = 0; s < 8; s++)
            if (c_vld[s] && c_tag[s] == line && slot < 0) slot = s;
        for (int s = 0; s < 8; s++)
            if (!c_vld[s] && slot < 0) slot = s;
        if (slot < 0) slot = 0;
        c_vld[slot] = 1'b1;
        c_tag[slot] = line;
        c_dat[slot] = dat;
    endtask

    task automatic add_backing(input logic [27:0] line, input logic [127:0] dat);
        be_tag[be_n] = line;
        be_dat[be_n] = dat;
        be_n++;
    endtask

    // Memory responder and cache-array writer, stepped on the falling edge.
    task automatic mem_loop();
        int req_cnt;
        req_cnt = 0;
        forever begin
            @(negedge clk);
            mem_ack_i = 1'b0;
            if (inject_ack) begin
                mem_ack_i  = 1'b1;
                mem_data_i = {8{16'hDEAD}};
                inject_ack = 1'b0;
            end else if (mem_req_o === 1'b1) begin
                req_cycles++;
                if (req_cnt >= ack_dly) begin
                    mem_ack_i     = 1'b1;
                    mem_data_i    = backing(mem_line_o);
                    last_mem_line = mem_line_o;
                    req_cnt       = 0;
                end else begin
                    req_cnt++;
                end
            end else begin
                req_cnt = 0;
            end
            if (fill_we_o === 1'b1) begin
                cache_write(fill_line_o, fill_data_o);
                fills++;
                last_fill_line = fill_line_o;
            end
        end
    endtask

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (instr_valid_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got instr %08h, required no response", instr_o);
                end else begin
                    e = exp_q.pop_front();
                    check32($sformatf("resp%0d_instr", e.id), instr_o, e.instr);
                    check32($sformatf("resp%0d_compressed", e.id), 32'(instr_compressed_o), 32'(e.comp));
                    check32($sformatf("resp%0d_cycle", e.id), 32'(cyc), 32'(e.cyc));
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns in the first cycle after the accepting edge.
    task automatic issue(input logic [31:0] pc, input int lat, input logic [31:0] instr,
                         input logic comp, input int id, input bit expect_rsp);
        int w;
        w = 0;
        while (fetch_ready_o !== 1'b1 && w < 50) begin
            step();
            w++;
        end
        if (fetch_ready_o !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout%0d: got ready %b, required 1", id, fetch_ready_o);
        end
        fetch_req_i = 1'b1;
        fetch_pc_i  = pc;
        if (expect_rsp) exp_q.push_back('{instr, comp, cyc + lat, id});
        step();
        fetch_req_i = 1'b0;
        fetch_pc_i  = 32'hDEAD_BEE0;
    endtask

    task automatic drain(input int id);
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            step();
            w++;
        end
        check32($sformatf("drain%0d_pending", id), 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (2) step();
    endtask

    initial begin
        int f0;
        int r0;
        int w;
        rst_i       = 1'b1;
        fetch_req_i = 1'b0;
        fetch_pc_i  = '0;
        mem_ack_i   = 1'b0;
        mem_data_i  = '0;
        fork
            mem_loop();
            monitor_loop();
        join_none

        repeat (2) step();
        check32("rst_ready",      32'(fetch_ready_o), 32'd1);
        check32("rst_valid",      32'(instr_valid_o), 32'd0);
        check32("rst_instr",      instr_o, 32'd0);
        check32("rst_compressed", 32'(instr_compressed_o), 32'd0);
        check32("rst_mem_req",    32'(mem_req_o), 32'd0);
        check32("rst_mem_line",   32'(mem_line_o), 32'd0);
        check32("rst_fill_we",    32'(fill_we_o), 32'd0);
        check32("rst_fill_line",  32'(fill_line_o), 32'd0);
        check32("rst_fill_data",  32'(|fill_data_o), 32'd0);
        rst_i = 1'b0;
        step();

        // Compressed hit, with the ready timing around it.
        cache_write(28'h100, blk_with(FILLER, 3, 16'h4501));
        issue(32'h0000_1006, 2, 32'h0000_4501, 1'b1, 1, 1'b1);
        check32("t1_ready_c1", 32'(fetch_ready_o), 32'd0);
        step();
        check32("t1_ready_c2", 32'(fetch_ready_o), 32'd0);
        step();
        check32("t1_ready_c3", 32'(fetch_ready_o), 32'd1);
        drain(1);
        check32("t1_instr_hold", instr_o, 32'h0000_4501);
        check32("t1_comp_hold",  32'(instr_compressed_o), 32'd1);

        // 32-bit instruction inside one line, no refill traffic.
        cache_write(28'h100, blk_with(blk_with(FILLER, 2, 16'h0513), 3, 16'h0010));
        r0 = req_cycles;
        issue(32'h0000_1004, 2, 32'h0010_0513, 1'b0, 2, 1'b1);
        drain(2);
        check32("t2_no_mem_req", 32'(req_cycles - r0), 32'd0);

        // Miss on line 0x200, ack four cycles after the request rises.
        add_backing(28'h200, blk_with(FILLER, 0, 16'h8082));
        ack_dly = 4;
        f0 = fills;
        issue(32'h0000_2000, 9, 32'h0000_8082, 1'b1, 3, 1'b1);
        drain(3);
        check32("t3_fill_count", 32'(fills - f0), 32'd1);
        check32("t3_fill_line",  32'(last_fill_line), 32'h200);
        check32("t3_mem_line",   32'(last_mem_line), 32'h200);

        // Straddle: low half hits in 0x300, upper half needs a refill of 0x301.
        cache_write(28'h300, blk_with(FILLER, 7, 16'h0093));
        add_backing(28'h301, blk_with(FILLER, 0, 16'h0010));
        ack_dly = 0;
        f0 = fills;
        issue(32'h0000_300E, 6, 32'h0010_0093, 1'b0, 4, 1'b1);
        drain(4);
        check32("t4_fill_count", 32'(fills - f0), 32'd1);
        check32("t4_fill_line",  32'(last_fill_line), 32'h301);
        check32("t4_mem_line",   32'(last_mem_line), 32'h301);

        // Next-line address wraps to line 0.
        cache_write(28'hFFF_FFFF, blk_with(FILLER, 7, 16'h1117));
        cache_write(28'h000_0000, blk_with(FILLER, 0, 16'hABCD));
        issue(32'hFFFF_FFFE, 3, 32'hABCD_1117, 1'b0, 5, 1'b1);
        check32("t5_look0_line", 32'(lookup_line_o), 32'h0FFF_FFFF);
        step();
        check32("t5_look1_line", 32'(lookup_line_o), 32'h0000_0000);
        drain(5);

        // Reset while waiting on a refill, followed by a stray ack.
        ack_dly = 1000;
        f0 = fills;
        issue(32'h0000_5000, 0, 32'h0, 1'b0, 6, 1'b0);
        w = 0;
        while (mem_req_o !== 1'b1 && w < 20) begin
            step();
            w++;
        end
        check32("t6_mem_req_seen", 32'(mem_req_o), 32'd1);
        check32("t6_mem_line",     32'(mem_line_o), 32'h500);
        rst_i = 1'b1;
        step();
        rst_i      = 1'b0;
        inject_ack = 1'b1;
        check32("t6_rst_ready",   32'(fetch_ready_o), 32'd1);
        check32("t6_rst_mem_req", 32'(mem_req_o), 32'd0);
        check32("t6_rst_fill_we", 32'(fill_we_o), 32'd0);
        check32("t6_rst_valid",   32'(instr_valid_o), 32'd0);
        repeat (6) step();
        check32("t6_no_fill",     32'(fills - f0), 32'd0);
        check32("t6_idle_ready",  32'(fetch_ready_o), 32'd1);
        check32("t6_instr_reset", instr_o, 32'd0);

        // Normal operation resumes after the abandoned refill.
        ack_dly = 0;
        issue(32'h0000_1004, 2, 32'h0010_0513, 1'b0, 7, 1'b1);
        drain(7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
